// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_pkg
//  Description : Shared definitions for the traffic-light phase controller:
//                3-bit phase encodings, per-head lamp vectors {r,y,g} and a
//                width helper for the timer counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    // Phase encodings, also exported on the debug 'phase' port
    localparam logic [2:0] c_MAIN_GREEN  = 3'd0;
    localparam logic [2:0] c_MAIN_YELLOW = 3'd1;
    localparam logic [2:0] c_ALL_RED_1   = 3'd2;
    localparam logic [2:0] c_SIDE_GREEN  = 3'd3;
    localparam logic [2:0] c_SIDE_YELLOW = 3'd4;
    localparam logic [2:0] c_ALL_RED_2   = 3'd5;
    localparam logic [2:0] c_NIGHT       = 3'd6;

    // Lamp vectors for one signal head, ordered {r, y, g}
    localparam logic [2:0] c_LAMP_OFF = 3'b000;
    localparam logic [2:0] c_LAMP_R   = 3'b100;
    localparam logic [2:0] c_LAMP_Y   = 3'b010;
    localparam logic [2:0] c_LAMP_G   = 3'b001;

    // clog2 that never returns zero, so a count of 1 still gets a 1-bit register
    function automatic int tlc_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : tlc_pkg
`default_nettype wire

// File: rtl/tlc_sec_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_sec_timer
//  Description : Prescaler plus seconds counter for one phase. Both counters
//                restart on 'clear'. 'expired' rises on the final cycle of a
//                'dur'-second interval and stays high until the next clear;
//                the counters freeze at that point instead of wrapping.
//  Ports       : clk     - clock
//                reset   - synchronous active-low reset
//                clear   - restart the interval (phase transition)
//                dur     - interval length in seconds (>= 1)
//                expired - final cycle of the interval reached
//  Revision    : 1.0 - initial release
// ============================================================================
module tlc_sec_timer
    import tlc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int SEC_W         = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [SEC_W-1:0] dur,
    output logic             expired
);

    localparam int               c_PRE_W    = tlc_width(TICKS_PER_SEC);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICKS_PER_SEC - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic [SEC_W-1:0]   r_sec;
    logic               w_done;
    logic               w_last;

    // r_sec reaches dur only after the final cycle has passed; from then on
    // the interval stays expired so late demand is still seen.
    assign w_done  = (r_sec >= dur);
    assign w_last  = (r_pre == c_PRE_LAST) && (r_sec == (dur - 1'b1));
    assign expired = w_done | w_last;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (!w_done) begin
            if (r_pre == c_PRE_LAST) begin
                r_pre <= '0;
                r_sec <= r_sec + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

endmodule : tlc_sec_timer
`default_nettype wire

// File: rtl/tlc_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tlc_phase_ctrl
//  Description : Traffic-light phase controller. Cycles main/side heads
//                through green, yellow and all-red, serves side-road and
//                pedestrian demand, and runs a flashing-yellow night mode by
//                enabling an external blinker and gating both yellows with it.
//  Config      : TLC_PED_REQ_EN - when defined, ped_req is latched into a
//                pending request served with a walk lamp during SIDE_GREEN;
//                when undefined ped_req is ignored and walk stays 0.
//  Ports       : clk, reset (sync active-low)
//                side_sensor, ped_req, night_mode, blink   - inputs
//                blink_en, main_r/y/g, side_r/y/g, walk     - lamp outputs
//                phase                                      - debug state
//  Revision    : 1.0 - initial release
// ============================================================================
module tlc_phase_ctrl
    import tlc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int GREEN_MAIN_S  = 10,
    parameter int GREEN_SIDE_S  = 5,
    parameter int YELLOW_S      = 3,
    parameter int ALL_RED_S     = 1
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       side_sensor,
    input  logic       ped_req,
    input  logic       night_mode,
    input  logic       blink,
    output logic       blink_en,
    output logic       main_r,
    output logic       main_y,
    output logic       main_g,
    output logic       side_r,
    output logic       side_y,
    output logic       side_g,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int c_MAX_AB = (GREEN_MAIN_S > GREEN_SIDE_S) ? GREEN_MAIN_S : GREEN_SIDE_S;
    localparam int c_MAX_CD = (YELLOW_S > ALL_RED_S) ? YELLOW_S : ALL_RED_S;
    localparam int c_MAX_S  = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
    localparam int c_SEC_W  = tlc_width(c_MAX_S + 1);

    localparam logic [c_SEC_W-1:0] c_DUR_MAIN_G = c_SEC_W'(GREEN_MAIN_S);
    localparam logic [c_SEC_W-1:0] c_DUR_SIDE_G = c_SEC_W'(GREEN_SIDE_S);
    localparam logic [c_SEC_W-1:0] c_DUR_YELLOW = c_SEC_W'(YELLOW_S);
    localparam logic [c_SEC_W-1:0] c_DUR_ALLRED = c_SEC_W'(ALL_RED_S);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_SEC_W-1:0] w_dur;
    logic               w_clear;
    logic               w_expired;
    logic               w_demand;
    logic               w_ped_pending;
    logic [2:0]         w_main_lamps;
    logic [2:0]         w_side_lamps;
    logic               w_blink_en;

    // ------------------------------------------------------------------
    // Phase timer
    // ------------------------------------------------------------------
    always_comb begin
        w_dur = c_DUR_ALLRED;
        case (r_state)
            c_MAIN_GREEN:  w_dur = c_DUR_MAIN_G;
            c_MAIN_YELLOW: w_dur = c_DUR_YELLOW;
            c_SIDE_GREEN:  w_dur = c_DUR_SIDE_G;
            c_SIDE_YELLOW: w_dur = c_DUR_YELLOW;
            default:       w_dur = c_DUR_ALLRED;
        endcase
    end

    // Timers restart whenever the phase changes
    assign w_clear = (w_next != r_state);

    tlc_sec_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .SEC_W         (c_SEC_W)
    ) u_sec_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .dur     (w_dur),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // Pedestrian request
    // ------------------------------------------------------------------
`ifdef TLC_PED_REQ_EN
    logic r_ped_pending;
    logic r_ped_hold;   // request seen during the current walk, kept for the next side phase

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ped_pending <= 1'b0;
            r_ped_hold    <= 1'b0;
        end else if ((w_next == c_NIGHT) || (r_state == c_NIGHT)) begin
            r_ped_pending <= 1'b0;
            r_ped_hold    <= 1'b0;
        end else if (r_state == c_SIDE_GREEN) begin
            if (w_next != c_SIDE_GREEN) begin
                r_ped_pending <= r_ped_hold | ped_req;
                r_ped_hold    <= 1'b0;
            end else if (ped_req) begin
                r_ped_hold <= 1'b1;
            end
        end else if (ped_req) begin
            r_ped_pending <= 1'b1;
        end
    end

    assign w_ped_pending = r_ped_pending;
`else
    logic w_unused_ped;
    assign w_unused_ped  = ped_req;
    assign w_ped_pending = 1'b0;
`endif

    assign w_demand = side_sensor | w_ped_pending | night_mode;

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ALL_RED_2;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_MAIN_GREEN:  if (w_expired && w_demand) w_next = c_MAIN_YELLOW;
            c_MAIN_YELLOW: if (w_expired) w_next = c_ALL_RED_1;
            c_ALL_RED_1:   if (w_expired) w_next = night_mode ? c_NIGHT : c_SIDE_GREEN;
            c_SIDE_GREEN:  if (w_expired) w_next = c_SIDE_YELLOW;
            c_SIDE_YELLOW: if (w_expired) w_next = c_ALL_RED_2;
            c_ALL_RED_2:   if (w_expired) w_next = night_mode ? c_NIGHT : c_MAIN_GREEN;
            c_NIGHT:       if (!night_mode) w_next = c_ALL_RED_2;
            default:       w_next = c_ALL_RED_2;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_main_lamps = c_LAMP_R;
        w_side_lamps = c_LAMP_R;
        w_blink_en   = 1'b0;
        case (r_state)
            c_MAIN_GREEN:  w_main_lamps = c_LAMP_G;
            c_MAIN_YELLOW: w_main_lamps = c_LAMP_Y;
            c_SIDE_GREEN:  w_side_lamps = c_LAMP_G;
            c_SIDE_YELLOW: w_side_lamps = c_LAMP_Y;
            c_NIGHT: begin
                // Yellows follow the external blinker; reds and greens dark
                w_main_lamps = blink ? c_LAMP_Y : c_LAMP_OFF;
                w_side_lamps = blink ? c_LAMP_Y : c_LAMP_OFF;
                w_blink_en   = 1'b1;
            end
            default: begin
                w_main_lamps = c_LAMP_R;
                w_side_lamps = c_LAMP_R;
            end
        endcase
    end

    assign {main_r, main_y, main_g} = w_main_lamps;
    assign {side_r, side_y, side_g} = w_side_lamps;
    assign blink_en = w_blink_en;
    assign walk     = (r_state == c_SIDE_GREEN) & w_ped_pending;
    assign phase    = r_state;

endmodule : tlc_phase_ctrl
`default_nettype wire

// File: tb/tb_tlc_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlc_phase_ctrl
//  Description : Self-checking bench for tlc_phase_ctrl. Directed vector
//                table, hand-written multi-cycle sequences and a random run,
//                all compared each cycle against a cycle-count reference
//                model of the phase rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tlc_phase_ctrl;

    localparam int T  = 10;
    localparam int GM = 3;
    localparam int GS = 2;
    localparam int YS = 2;
    localparam int AR = 1;

`ifdef TLC_PED_REQ_EN
    localparam int c_EXP_WALK_LEN = 20;
    localparam int c_EXP_WALK     = 1;
`else
    localparam int c_EXP_WALK_LEN = 0;
    localparam int c_EXP_WALK     = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       side_sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic       blink = 1'b0;
    logic       blink_en;
    logic       main_r, main_y, main_g;
    logic       side_r, side_y, side_g;
    logic       walk;
    logic [2:0] phase;

    tlc_phase_ctrl #(
        .TICKS_PER_SEC (T),
        .GREEN_MAIN_S  (GM),
        .GREEN_SIDE_S  (GS),
        .YELLOW_S      (YS),
        .ALL_RED_S     (AR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .side_sensor (side_sensor),
        .ped_req     (ped_req),
        .night_mode  (night_mode),
        .blink       (blink),
        .blink_en    (blink_en),
        .main_r      (main_r),
        .main_y      (main_y),
        .main_g      (main_g),
        .side_r      (side_r),
        .side_y      (side_y),
        .side_g      (side_g),
        .walk        (walk),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int blink_cnt = 0;

    // Reference model: phase number, cycles spent in it, pedestrian state
    int m_ph = 5;
    int m_cnt = 0;
    bit m_pend = 1'b0;
    bit m_hold = 1'b0;
    bit m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dur_cycles(input int ph);
        case (ph)
            0:       return GM * T;
            1, 4:    return YS * T;
            2, 5:    return AR * T;
            3:       return GS * T;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit s, input bit p, input bit n);
        int  nxt;
        bit  done;
        if (!r) begin
            m_ph = 5; m_cnt = 0; m_pend = 1'b0; m_hold = 1'b0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        done = (m_cnt + 1 >= dur_cycles(m_ph));
        nxt  = m_ph;
        case (m_ph)
            0: if (done && (s || m_pend || n)) nxt = 1;
            1: if (done) nxt = 2;
            2: if (done) nxt = n ? 6 : 3;
            3: if (done) nxt = 4;
            4: if (done) nxt = 5;
            5: if (done) nxt = n ? 6 : 0;
            6: if (!n) nxt = 5;
            default: nxt = 5;
        endcase
`ifdef TLC_PED_REQ_EN
        if (nxt == 6 || m_ph == 6) begin
            m_pend = 1'b0; m_hold = 1'b0;
        end else if (m_ph == 3) begin
            if (nxt != 3) begin
                m_pend = m_hold | p; m_hold = 1'b0;
            end else if (p) begin
                m_hold = 1'b1;
            end
        end else if (p) begin
            m_pend = 1'b1;
        end
`endif
        m_cnt = (nxt != m_ph) ? 0 : ((m_cnt < 1000000) ? m_cnt + 1 : m_cnt);
        m_ph  = nxt;
    endtask

    // {blink_en, main rgy, side rgy, walk, phase}
    function automatic logic [10:0] model_vec();
        logic mr, my, mg, sr, sy, sg;
        mr = (m_ph >= 2 && m_ph <= 5);
        my = (m_ph == 1) || (m_ph == 6 && blink);
        mg = (m_ph == 0);
        sr = (m_ph <= 2) || (m_ph == 5);
        sy = (m_ph == 4) || (m_ph == 6 && blink);
        sg = (m_ph == 3);
        return {(m_ph == 6), mr, my, mg, sr, sy, sg, (m_ph == 3) && m_pend, 3'(m_ph)};
    endfunction

    task automatic tick(input logic r, input logic s, input logic p, input logic n);
        reset = r; side_sensor = s; ped_req = p; night_mode = n;
        blink_cnt++;
        blink = blink_cnt[2];
        #1;
        if (m_valid)
            chk("model", 32'({blink_en, main_r, main_y, main_g, side_r, side_y, side_g, walk, phase}),
                32'(model_vec()));
        @(posedge clk);
        model_step(r, s, p, n);
        #1;
    endtask

    typedef struct packed {
        logic        rst;
        logic        side;
        logic        ped;
        logic        night;
        logic [15:0] n;
        logic [2:0]  ph;
        logic [2:0]  ml;
        logic [2:0]  sl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, s, p, n, input int cyc,
                                input logic [2:0] ph, ml, sl);
        vec_t v;
        v.rst = r; v.side = s; v.ped = p; v.night = n;
        v.n = 16'(cyc); v.ph = ph; v.ml = ml; v.sl = sl;
        return v;
    endfunction

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit rs, rn;

        // reset, rest, full cycle with late demand, then demand from entry
        tbl.push_back(mk(0, 0, 0, 0,   2, 3'd5, R, R));
        tbl.push_back(mk(1, 0, 0, 0,   9, 3'd5, R, R));
        tbl.push_back(mk(1, 0, 0, 0,   1, 3'd0, G, R));
        tbl.push_back(mk(1, 0, 0, 0, 500, 3'd0, G, R));
        tbl.push_back(mk(1, 1, 0, 0,   1, 3'd1, Y, R));
        tbl.push_back(mk(1, 0, 0, 0,  19, 3'd1, Y, R));
        tbl.push_back(mk(1, 0, 0, 0,   1, 3'd2, R, R));
        tbl.push_back(mk(1, 0, 0, 0,   9, 3'd2, R, R));
        tbl.push_back(mk(1, 0, 0, 0,   1, 3'd3, R, G));
        tbl.push_back(mk(1, 0, 0, 0,  19, 3'd3, R, G));
        tbl.push_back(mk(1, 0, 0, 0,   1, 3'd4, R, Y));
        tbl.push_back(mk(1, 0, 0, 0,  19, 3'd4, R, Y));
        tbl.push_back(mk(1, 0, 0, 0,   1, 3'd5, R, R));
        tbl.push_back(mk(1, 0, 0, 0,   9, 3'd5, R, R));
        tbl.push_back(mk(1, 0, 0, 0,   1, 3'd0, G, R));
        tbl.push_back(mk(1, 1, 0, 0,  29, 3'd0, G, R));
        tbl.push_back(mk(1, 1, 0, 0,   1, 3'd1, Y, R));
        tbl.push_back(mk(1, 1, 0, 0,  20, 3'd2, R, R));
        tbl.push_back(mk(1, 1, 0, 0,  10, 3'd3, R, G));
        tbl.push_back(mk(1, 1, 0, 0,  20, 3'd4, R, Y));
        tbl.push_back(mk(1, 1, 0, 0,  20, 3'd5, R, R));
        tbl.push_back(mk(1, 1, 0, 0,   9, 3'd5, R, R));
        tbl.push_back(mk(1, 0, 0, 0,   1, 3'd0, G, R));

        for (int k = 0; k < tbl.size(); k++) begin
            for (int c = 0; c < int'(tbl[k].n); c++)
                tick(tbl[k].rst, tbl[k].side, tbl[k].ped, tbl[k].night);
            chk($sformatf("vec%0d", k),
                32'({phase, main_r, main_y, main_g, side_r, side_y, side_g}),
                32'({tbl[k].ph, tbl[k].ml, tbl[k].sl}));
            if (k == 0)
                chk("reset_misc", 32'({walk, blink_en}), 32'(0));
        end

        // Pedestrian pulse at MAIN_GREEN entry
        tick(1, 0, 1, 0);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1, 0, 0, 0);
            if (walk === 1'b1) cnt++;
        end
        chk("walk_len", 32'(cnt), 32'(c_EXP_WALK_LEN));
        chk("ped_end_phase", 32'(phase), 32'd0);

        // Night entry from expired main green
        cnt = 0;
        for (int i = 0; i < 100 && phase !== 3'd6; i++) begin
            tick(1, 0, 0, 1);
            cnt++;
        end
        chk("night_entry_cycles", 32'(cnt), 32'd31);
        for (int i = 0; i < 12; i++) begin
            tick(1, 0, 0, 1);
            chk("night_lamps", 32'({main_r, main_g, side_r, side_g, blink_en, main_y, side_y}),
                32'({4'b0000, 1'b1, blink, blink}));
        end
        tick(1, 0, 0, 0);
        chk("night_exit", 32'(phase), 32'd5);
        for (int i = 0; i < 9; i++) tick(1, 0, 0, 0);
        chk("night_ar2_hold", 32'(phase), 32'd5);
        tick(1, 0, 0, 0);
        chk("night_to_main", 32'(phase), 32'd0);

        // Reset in the middle of a walk
        tick(1, 1, 1, 0);
        for (int i = 0; i < 100 && phase !== 3'd3; i++) tick(1, 1, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("mid_walk", 32'({phase, walk}), 32'({3'd3, 1'(c_EXP_WALK)}));
        tick(0, 0, 0, 0);
        chk("mid_reset", 32'({phase, main_r, main_y, main_g, side_r, side_y, side_g, walk, blink_en}),
            32'({3'd5, R, R, 2'b00}));
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 0);
        chk("mid_release", 32'(phase), 32'd0);
        for (int i = 0; i < 100; i++) tick(1, 0, 0, 0);
        chk("mid_no_pending", 32'(phase), 32'd0);

        // Random run against the model
        rs = 1'b0; rn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0)  rs = ~rs;
            if ($urandom_range(0, 399) == 0) rn = ~rn;
            tick(($urandom_range(0, 499) != 0), rs, ($urandom_range(0, 59) == 0), rn);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tlc_phase_ctrl
`default_nettype wire

// File: doc/tlc_phase_ctrl.md
# tlc_phase_ctrl

Traffic-light phase controller for the ZCU104 TLC design. It sequences the main-road and side-road signal heads through green, yellow and all-red phases, and serves side-road vehicle and pedestrian demand. It enters a flashing-yellow night mode by driving the enable of an external blinker and gating both yellow heads with that blinker's `blink` output.

## Interface
- `TICKS_PER_SEC`, 1000: clk cycles per second; 1000 for simulation, 50_000_000 on board; ≥1.
- `GREEN_MAIN_S`, 10: minimum main green, seconds; ≥1.
- `GREEN_SIDE_S`, 5: fixed side green, seconds; ≥1.
- `YELLOW_S`, 3: yellow duration, both roads; ≥1.
- `ALL_RED_S`, 1: all-red clearance, seconds; ≥1.

- `clk` in 1: single clock; all state on posedge.
- `reset` in 1: synchronous, active-low. `reset`=0 at a posedge resets the block.
- `side_sensor` in 1: level; side-road vehicle waiting.
- `ped_req` in 1: pedestrian button; any 1-cycle pulse is captured.
- `night_mode` in 1: level; request flashing operation.
- `blink` in 1: square wave from the external blinker.
- `blink_en` out 1: enable to the blinker.
- `main_r`, `main_y`, `main_g` out 1 each: main-road head.
- `side_r`, `side_y`, `side_g` out 1 each: side-road head.
- `walk` out 1: pedestrian walk lamp.
- `phase` out 3: current state encoding, for debug.

## Operation
- States: `MAIN_GREEN`, `MAIN_YELLOW`, `ALL_RED_1`, `SIDE_GREEN`, `SIDE_YELLOW`, `ALL_RED_2`, `NIGHT`. Moore outputs are decoded from the state register.
- Light decode:
  - `MAIN_GREEN`: main G, side R.
  - `MAIN_YELLOW`: main Y, side R.
  - `ALL_RED_x`: both R.
  - `SIDE_GREEN`: side G, main R, `walk`=`ped_pending`.
  - `SIDE_YELLOW`: side Y, main R.
  - `NIGHT`: `main_y`=`side_y`=`blink`, all R/G=0, `blink_en`=1.
- `blink_en`=1 only in `NIGHT`.
- Demand = `side_sensor` | `ped_pending` | `night_mode`.
- `MAIN_GREEN`:
  - Once the minimum time has expired, the first cycle with demand=1 moves to `MAIN_YELLOW`.
  - Without demand the block rests in `MAIN_GREEN` indefinitely.
- `MAIN_YELLOW` → `ALL_RED_1` after `YELLOW_S`.
- `ALL_RED_1` expiry: go to `NIGHT` if `night_mode`, else `SIDE_GREEN`.
- `SIDE_GREEN` → `SIDE_YELLOW` after `GREEN_SIDE_S`. There is no extension.
- `SIDE_YELLOW` → `ALL_RED_2` after `YELLOW_S`.
- `ALL_RED_2` expiry: go to `NIGHT` if `night_mode`, else `MAIN_GREEN`.
- `NIGHT`: the first cycle with `night_mode`=0 moves to `ALL_RED_2`.
- Reset state is `ALL_RED_2`, so power-up is all red for `ALL_RED_S`, then `MAIN_GREEN`.

## Timing
- Every timed state lasts exactly D×`TICKS_PER_SEC` cycles. D is that state's parameter.
- The prescaler and second counter both clear on every state transition.
- Prescaler width: clog2(`TICKS_PER_SEC`). Second counter width: clog2(max duration + 1). Neither wraps inside a state.
- Expiry sampling:
  - Demand in `MAIN_GREEN` is sampled from the expiry cycle onward. The transition occurs at the posedge following the sampled cycle.
  - `night_mode` at `ALL_RED_x` expiry is sampled on the final cycle of that state.
- Reset values:
  - `main_r`=`side_r`=1.
  - All other lamps 0.
  - `blink_en`=0, `walk`=0, `phase`=`ALL_RED_2`.
  - `ped_pending`=0, timers 0.
- Reset mid-phase: all red on the cycle after the reset posedge, regardless of the prior state.

## Configuration
- `TLC_PED_REQ_EN` defined:
  - `ped_req` sets `ped_pending`. `ped_pending` clears at exit from `SIDE_GREEN`.
  - A request during `SIDE_GREEN` is held for the next cycle. It does not extend the current walk.
  - `ped_pending` is cleared on entry to `NIGHT`. `ped_req` is ignored while in `NIGHT`.
- `TLC_PED_REQ_EN` undefined: `ped_req` is ignored, `ped_pending` is constant 0, `walk` is tied to 0. The port list is unchanged.

## Structure
- Shared package `tlc_pkg` holds:
  - the 3-bit state encodings, `MAIN_GREEN`=0 … `NIGHT`=6;
  - lamp-vector localparams.
- Sub-module `tlc_sec_timer` provides the prescaler plus second counter, with inputs `clear` and `dur` and output `expired`. The FSM, demand logic and output decode remain in `tlc_phase_ctrl`.
- The blinker is instantiated alongside `tlc_phase_ctrl` at top level, never inside it.

## Test plan
All scenarios use `TICKS_PER_SEC`=10, `GREEN_MAIN_S`=3, `GREEN_SIDE_S`=2, `YELLOW_S`=2, `ALL_RED_S`=1.
- **Reset:** `reset`=0 for 2 cycles → both reds 1, all other outputs 0. After release: all red for 10 cycles, then `main_g`=1.
- **No demand:** hold all inputs 0 → `MAIN_GREEN` holds for 500 cycles with no change.
- **Side demand:** `side_sensor`=1 from `MAIN_GREEN` entry → phase lengths are main G 30, main Y 20, all-red 10, side G 20, side Y 20, all-red 10 cycles, then `MAIN_GREEN`.
- **Pedestrian:** 1-cycle `ped_req` pulse in `MAIN_GREEN` → with the macro, `walk`=1 for exactly the 20 `SIDE_GREEN` cycles. Without the macro, `walk` stays 0 and the block rests in `MAIN_GREEN`.
- **Night mode:** set `night_mode`=1 → `NIGHT` after `ALL_RED_1`, with `main_y`=`side_y`=`blink`, `blink_en`=1, reds 0. Clear `night_mode` → `ALL_RED_2` on the next cycle, `MAIN_GREEN` 10 cycles later.
- **Reset mid-phase:** `reset`=0 during `SIDE_GREEN` with `walk`=1 → on the next cycle all red, `walk`=0, `ped_pending`=0.
